// File: rtl/cnn_concat_nin.sv
// N-input channel concatenation: per-input FWFT FIFOs drained in ascending input order,
// block_len[i] words per input per group, over one valid/ready output with group-end marker.
module cnn_concat_nin #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 5,
    parameter int FIFO_DEPTH = 1024,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN-1:0]              valid_in,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_IN*LEN_WIDTH-1:0]    block_len,
    output logic [DATA_WIDTH-1:0]          out,
    output logic                           valid_out,
    input  logic                           out_ready,
    output logic                           last_out,
    output logic [$clog2(NUM_IN)-1:0]      sel_out,
    output logic [NUM_IN-1:0]              overflow,
    output logic                           busy
);

    // state  | meaning
    // IDLE   | between groups; latches block_len and may pop the first word combinationally
    // STREAM | draining FIFO[sel] for the current block of the group

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(NUM_IN);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state, state_n;
    logic [SW-1:0]          sel, sel_n;
    logic [LEN_WIDTH-1:0]   cnt, cnt_n;
    logic [LEN_WIDTH-1:0]   len_in [NUM_IN];
    logic [LEN_WIDTH-1:0]   len_q  [NUM_IN];

    logic [DATA_WIDTH-1:0]  head [NUM_IN];
    logic [NUM_IN-1:0]      empty;
    logic [NUM_IN-1:0]      push;
    logic [NUM_IN-1:0]      pop;
    logic [NUM_IN-1:0]      ovf_set;

    logic [NUM_IN-1:0]      eff_nz;
    logic [SW-1:0]          first_sel;
    logic [SW-1:0]          eff_sel;
    logic [SW-1:0]          next_sel;
    logic [LEN_WIDTH-1:0]   eff_cnt;
    logic [LEN_WIDTH-1:0]   eff_len_cur;
    logic                   more;
    logic                   active;
    logic                   adv;
    logic                   do_pop;
    logic                   block_end;
    logic                   group_end;

    // ---------------------------------------------------------------- input FIFOs
    for (genvar g = 0; g < NUM_IN; g++) begin : g_fifo
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]         wr_ptr;
        logic [AW-1:0]         rd_ptr;
        logic [AW:0]           count;

        assign empty[g]   = (count == '0);
        assign push[g]    = valid_in[g] && ((count != FULL_CNT) || pop[g]);
        assign ovf_set[g] = valid_in[g] && !push[g];
        assign head[g]    = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr] <= in_data[g*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
                case ({push[g], pop[g]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= '0;
        end else begin
            overflow <= overflow | ovf_set;
        end
    end

    // ---------------------------------------------------------------- length selection
    // In IDLE the live block_len drives selection so a group can start without a bubble.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            len_in[i] = block_len[i*LEN_WIDTH +: LEN_WIDTH];
            if (state == IDLE) begin
                eff_nz[i] = (len_in[i] != '0);
            end else begin
                eff_nz[i] = (len_q[i] != '0);
            end
        end
    end

    always_comb begin
        first_sel = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (eff_nz[i]) first_sel = SW'(i);
        end
    end

    always_comb begin
        if (state == IDLE) begin
            active      = |eff_nz;
            eff_sel     = first_sel;
            eff_cnt     = '0;
            eff_len_cur = len_in[first_sel];
        end else begin
            active      = 1'b1;
            eff_sel     = sel;
            eff_cnt     = cnt;
            eff_len_cur = len_q[sel];
        end
    end

    always_comb begin
        next_sel = '0;
        more     = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (eff_nz[i] && (SW'(i) > eff_sel)) begin
                next_sel = SW'(i);
                more     = 1'b1;
            end
        end
    end

    assign adv       = !valid_out || out_ready;
    assign do_pop    = active && adv && !empty[eff_sel];
    assign block_end = (eff_cnt == eff_len_cur - 1'b1);
    assign group_end = block_end && !more;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            pop[i] = do_pop && (SW'(i) == eff_sel);
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            cnt   <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state <= state_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            if (state == IDLE) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    len_q[i] <= len_in[i];
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt;
        if (state == IDLE && active) begin
            state_n = STREAM;
            sel_n   = first_sel;
            cnt_n   = '0;
        end
        if (do_pop) begin
            if (block_end) begin
                cnt_n = '0;
                if (more) begin
                    sel_n = next_sel;
                end else begin
                    state_n = IDLE;
                end
            end else begin
                cnt_n = eff_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- output register
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            sel_out   <= '0;
        end else if (adv) begin
            if (do_pop) begin
                out       <= head[eff_sel];
                valid_out <= 1'b1;
                last_out  <= group_end;
                sel_out   <= eff_sel;
            end else begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end
        end
    end

    assign busy = (state == STREAM) || (|(~empty)) || valid_out;

endmodule

// File: tb/tb_cnn_concat_nin.sv
// Directed bench for cnn_concat_nin: a queue-based group model checks every output cycle,
// and hand-computed literals pin the expected word order of each scenario.
module tb_cnn_concat_nin;
    localparam int DW    = 32;
    localparam int NI    = 5;
    localparam int DEPTH = 16;
    localparam int LW    = 16;

    logic                 clk;
    logic                 reset;
    logic [NI-1:0]        valid_in;
    logic [NI*DW-1:0]     in_data;
    logic [NI*LW-1:0]     block_len;
    logic [DW-1:0]        out;
    logic                 valid_out;
    logic                 out_ready;
    logic                 last_out;
    logic [2:0]           sel_out;
    logic [NI-1:0]        overflow;
    logic                 busy;

    cnn_concat_nin #(
        .DATA_WIDTH(DW), .NUM_IN(NI), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .in_data(in_data),
        .block_len(block_len), .out(out), .valid_out(valid_out), .out_ready(out_ready),
        .last_out(last_out), .sel_out(sel_out), .overflow(overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    logic [DW-1:0] q [NI][$];
    int            cfg_len [NI];
    bit            grp_started;
    int            grp_sel;
    int            grp_cnt;
    logic [NI-1:0] exp_ovf;
    int            emitted;
    bit            prev_rst;
    logic [DW-1:0] seen_data [$];
    int            seen_sel  [$];
    bit            seen_last [$];

    int vectors;
    int miscompares;

    int s_cur;
    int n_nxt;
    bit lexp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_nz();
        for (int i = 0; i < NI; i++) if (cfg_len[i] != 0) return i;
        return -1;
    endfunction

    function automatic int next_nz(input int s);
        for (int i = s + 1; i < NI; i++) if (cfg_len[i] != 0) return i;
        return -1;
    endfunction

    // Compare DUT against the model, then apply this cycle's transfers/pushes to the model.
    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_out", out, 0);
            chk("rst_valid", valid_out, 0);
            chk("rst_last", last_out, 0);
            chk("rst_sel", sel_out, 0);
            chk("rst_ovf", overflow, 0);
        end else begin
            chk("overflow", overflow, exp_ovf);
            if (valid_out) begin
                s_cur = grp_started ? grp_sel : first_nz();
                if (s_cur < 0 || q[s_cur].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_word: got %0h expected no word at %0t", out, $time);
                end else begin
                    lexp = (grp_cnt + 1 == cfg_len[s_cur]) && (next_nz(s_cur) < 0);
                    chk("out", out, q[s_cur][0]);
                    chk("sel_out", sel_out, s_cur);
                    chk("last_out", last_out, lexp);
                    if (out_ready && !reset) begin
                        seen_data.push_back(q[s_cur].pop_front());
                        seen_sel.push_back(s_cur);
                        seen_last.push_back(lexp);
                        emitted++;
                        grp_started = 1;
                        grp_sel = s_cur;
                        grp_cnt++;
                        if (grp_cnt == cfg_len[s_cur]) begin
                            grp_cnt = 0;
                            n_nxt = next_nz(s_cur);
                            if (n_nxt < 0) grp_started = 0;
                            else grp_sel = n_nxt;
                        end
                    end
                end
            end
        end
        if (reset) begin
            for (int i = 0; i < NI; i++) q[i].delete();
            grp_started = 0;
            grp_sel = 0;
            grp_cnt = 0;
            exp_ovf = '0;
            prev_rst = 1;
        end else begin
            prev_rst = 0;
            for (int i = 0; i < NI; i++) begin
                if (valid_in[i]) begin
                    if (q[i].size() < DEPTH) q[i].push_back(in_data[i*DW +: DW]);
                    else exp_ovf[i] = 1'b1;
                end
            end
        end
    end

    task automatic set_len(input int l0, input int l1, input int l2, input int l3, input int l4);
        cfg_len[0] = l0; cfg_len[1] = l1; cfg_len[2] = l2; cfg_len[3] = l3; cfg_len[4] = l4;
        for (int i = 0; i < NI; i++) block_len[i*LW +: LW] = LW'(cfg_len[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        emitted = 0;
        seen_data.delete();
        seen_sel.delete();
        seen_last.delete();
    endtask

    task automatic push(input int i, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            valid_in = '0;
            valid_in[i] = 1'b1;
            in_data[i*DW +: DW] = DW'(base + k);
        end
        @(posedge clk);
        #1 valid_in = '0;
    endtask

    task automatic push_group(input int base);
        for (int i = 0; i < NI; i++) push(i, 4, base + i * 16);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_emit(input int n, input string name);
        int c;
        c = 0;
        while (emitted < n && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (emitted < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d words expected %0d", name, emitted, n);
        end
    endtask

    function automatic int count_last();
        int t;
        t = 0;
        foreach (seen_last[k]) t += seen_last[k];
        return t;
    endfunction

    initial begin
        vectors = 0; miscompares = 0; emitted = 0; prev_rst = 0;
        exp_ovf = '0; grp_started = 0; grp_sel = 0; grp_cnt = 0;
        reset = 1'b1; valid_in = '0; in_data = '0; block_len = '0; out_ready = 1'b1;
        set_len(0, 0, 0, 0, 0);

        // T1: all len 4, in-order 20 words
        set_len(4, 4, 4, 4, 4);
        do_reset();
        chk("t1_busy_after_reset", busy, 0);
        chk("t1_valid_after_reset", valid_out, 0);
        push_group('hA0);
        wait_emit(20, "t1");
        idle(3);
        chk("t1_first", seen_data[0], 'hA0);
        chk("t1_word20", seen_data[19], 'hE3);
        chk("t1_last20", seen_last[19], 1);
        chk("t1_last19", seen_last[18], 0);
        chk("t1_sel5", seen_sel[4], 1);
        chk("t1_sel17", seen_sel[16], 4);
        chk("t1_last_count", count_last(), 1);

        // T2: skipped inputs
        set_len(3, 0, 2, 0, 1);
        do_reset();
        push(0, 3, 'h10);
        push(1, 2, 'h20);
        push(2, 2, 'h30);
        push(3, 2, 'h40);
        push(4, 1, 'h50);
        wait_emit(6, "t2");
        idle(5);
        chk("t2_count", emitted, 6);
        chk("t2_w0", seen_data[0], 'h10);
        chk("t2_w2", seen_data[2], 'h12);
        chk("t2_w3", seen_data[3], 'h30);
        chk("t2_w5", seen_data[5], 'h50);
        chk("t2_sel3", seen_sel[3], 2);
        chk("t2_last", seen_last[5], 1);
        chk("t2_busy", busy, 1);

        // T3: in4 arrives first
        set_len(4, 4, 4, 4, 4);
        do_reset();
        push(4, 4, 'hE0);
        idle(6);
        chk("t3_no_early_valid", valid_out, 0);
        chk("t3_no_early_words", emitted, 0);
        for (int i = 0; i < 4; i++) push(i, 4, 'hA0 + i * 16);
        wait_emit(20, "t3");
        chk("t3_first", seen_data[0], 'hA0);
        chk("t3_w17", seen_data[16], 'hE0);
        chk("t3_w20", seen_data[19], 'hE3);

        // T4: backpressure mid-block
        set_len(4, 4, 4, 4, 4);
        do_reset();
        push(0, 4, 'hA0);
        wait_emit(2, "t4a");
        out_ready = 1'b0;
        idle(7);
        chk("t4_held_valid", valid_out, 1);
        chk("t4_held_word", out, 'hA2);
        out_ready = 1'b1;
        for (int i = 1; i < NI; i++) push(i, 4, 'hA0 + i * 16);
        wait_emit(20, "t4");
        idle(3);
        chk("t4_count", emitted, 20);
        chk("t4_w3", seen_data[2], 'hA2);
        chk("t4_w4", seen_data[3], 'hA3);
        chk("t4_w20", seen_data[19], 'hE3);

        // T5: overflow on in2
        set_len(0, 0, 0, 0, 0);
        do_reset();
        chk("t5_busy_idle", busy, 0);
        push(2, DEPTH + 1, 'h200);
        idle(2);
        chk("t5_overflow", overflow, 5'b00100);
        chk("t5_busy_full", busy, 1);
        chk("t5_nothing_out", valid_out, 0);
        set_len(0, 0, DEPTH, 0, 0);
        wait_emit(DEPTH, "t5");
        idle(3);
        chk("t5_count", emitted, DEPTH);
        chk("t5_first", seen_data[0], 'h200);
        chk("t5_lastword", seen_data[DEPTH-1], 'h200 + DEPTH - 1);
        chk("t5_lastflag", seen_last[DEPTH-1], 1);
        chk("t5_overflow_sticky", overflow, 5'b00100);

        // T6: reset mid-group
        set_len(4, 4, 4, 4, 4);
        do_reset();
        out_ready = 1'b0;
        push_group('h100);
        out_ready = 1'b1;
        wait_emit(9, "t6a");
        chk("t6_w9", seen_data[8], 'h120);
        do_reset();
        chk("t6_out_zero", out, 0);
        chk("t6_valid_zero", valid_out, 0);
        chk("t6_busy_zero", busy, 0);
        push_group('hA0);
        wait_emit(20, "t6");
        idle(3);
        chk("t6_count", emitted, 20);
        chk("t6_first", seen_data[0], 'hA0);
        chk("t6_w20", seen_data[19], 'hE3);
        chk("t6_last", seen_last[19], 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1, "watchdog");
    end
endmodule
